// File: rtl/hybrid16_arbiter.sv
// Round-robin arbiter sharing one hybridadder16 among NREQ lanes, with a one-entry result buffer.
// Optional carry-out output enabled by defining HYB_ARB_COUT_EN.

module hybridadder16 (
  input  logic [15:0] i_x1,
  input  logic [15:0] i_x2,
  output logic [15:0] o_s
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;

  assign w_g    = i_x1 & i_x2;
  assign w_p    = i_x1 ^ i_x2;
  assign w_c[0] = 1'b0;

  // Four 4-bit lookahead groups with the group carry rippled between them
  for (genvar b = 0; b < 4; b++) begin : g_blk
    localparam int unsigned L = 4 * b;
    assign w_c[L+1] = w_g[L] | (w_p[L] & w_c[L]);
    assign w_c[L+2] = w_g[L+1] | (w_p[L+1] & w_g[L]) | (w_p[L+1] & w_p[L] & w_c[L]);
    assign w_c[L+3] = w_g[L+2] | (w_p[L+2] & w_g[L+1]) | (w_p[L+2] & w_p[L+1] & w_g[L])
                    | (w_p[L+2] & w_p[L+1] & w_p[L] & w_c[L]);
    if (b < 3) begin : g_co
      assign w_c[L+4] = w_g[L+3] | (w_p[L+3] & w_g[L+2]) | (w_p[L+3] & w_p[L+2] & w_g[L+1])
                      | (w_p[L+3] & w_p[L+2] & w_p[L+1] & w_g[L])
                      | (w_p[L+3] & w_p[L+2] & w_p[L+1] & w_p[L] & w_c[L]);
    end
  end

  assign o_s = w_p ^ w_c;
endmodule

module hybrid16_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [16*NREQ-1:0] i_req_x1,
  input  logic [16*NREQ-1:0] i_req_x2,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_rsp_valid,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [15:0]        o_rsp_s,
`ifdef HYB_ARB_COUT_EN
  output logic               o_rsp_cout,
`endif
  input  logic               i_rsp_ready
);
  logic [IDW-1:0] r_ptr;
  logic           r_full;
  logic [IDW-1:0] r_id;
  logic [15:0]    r_s;

  logic           w_can_acc;
  logic           w_found;
  logic           w_grant;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_ptr_nxt;
  logic [31:0]    w_idx;
  logic [15:0]    w_x1_arr [NREQ];
  logic [15:0]    w_x2_arr [NREQ];
  logic [15:0]    w_x1;
  logic [15:0]    w_x2;
  logic [15:0]    w_sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_x1_arr[i] = i_req_x1[16*i +: 16];
    assign w_x2_arr[i] = i_req_x2[16*i +: 16];
  end

  // Gating on reset keeps req_ready low while the block is held in reset
  assign w_can_acc = i_rst_n && (!r_full || i_rsp_ready);

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req_valid[IDW'(w_idx)]) begin
        w_found  = 1'b1;
        w_gnt_id = IDW'(w_idx);
      end
    end
  end

  assign w_grant   = w_can_acc && w_found;
  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;

  always_comb begin
    o_req_ready = '0;
    if (w_grant) o_req_ready[w_gnt_id] = 1'b1;
  end

  assign w_x1 = w_x1_arr[w_gnt_id];
  assign w_x2 = w_x2_arr[w_gnt_id];

  hybridadder16 u_adder (
    .i_x1 (w_x1),
    .i_x2 (w_x2),
    .o_s  (w_sum)
  );

`ifdef HYB_ARB_COUT_EN
  logic r_cout;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     r_cout <= 1'b0;
    else if (w_grant) r_cout <= (w_sum < w_x1);
  end
  assign o_rsp_cout = r_cout;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
      r_id   <= '0;
      r_s    <= '0;
    end else if (w_grant) begin
      r_ptr  <= w_ptr_nxt;
      r_full <= 1'b1;
      r_id   <= w_gnt_id;
      r_s    <= w_sum;
    end else if (i_rsp_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_rsp_valid = r_full;
  assign o_rsp_id    = r_id;
  assign o_rsp_s     = r_s;
endmodule

// File: tb/tb_hybrid16_arbiter.sv
// Directed self-checking bench for hybrid16_arbiter (NREQ = 4).
module tb_hybrid16_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_x1;
  logic [63:0] req_x2;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_s;
  logic        rsp_ready;
`ifdef HYB_ARB_COUT_EN
  logic        rsp_cout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Expected sums per lane for the base operand set
  logic [15:0] sums [4] = '{16'h0003, 16'h0100, 16'h2200, 16'h0000};

  hybrid16_arbiter #(.NREQ(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_x1    (req_x1),
    .i_req_x2    (req_x2),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_s     (rsp_s),
`ifdef HYB_ARB_COUT_EN
    .o_rsp_cout  (rsp_cout),
`endif
    .i_rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_x1    = {16'hFFFF, 16'h1234, 16'h00FF, 16'h0001};
    req_x2    = {16'h0001, 16'h0FCC, 16'h0001, 16'h0002};

    // Reset with all lanes valid
    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_s", 32'(rsp_s), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);

    // All lanes valid: grant order 0,1,2,3,0,1
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_req_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_rsp_s", 32'(rsp_s), 32'(sums[k % 4]));
`ifdef HYB_ARB_COUT_EN
      chk("rr_rsp_cout", 32'(rsp_cout), (k % 4 == 3) ? 32'h1 : 32'h0);
`endif
    end

    // Drain with nothing requesting
    req_valid = 4'b0000;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);

    // Single lane 2 (ptr = 2)
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);
    chk("single_rsp_s", 32'(rsp_s), 32'h2200);
    tick();
    chk("single_drain", 32'(rsp_valid), 32'h0);

    // Fill buffer with id 1, 0x8000 + 0x7FFF, then backpressure (ptr = 3 searches 3,0,1)
    req_x1[31:16] = 16'h8000;
    req_x2[31:16] = 16'h7FFF;
    req_valid     = 4'b0010;
    rsp_ready     = 1'b0;
    #1;
    chk("bp_fill_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_id", 32'(rsp_id), 32'h1);
      chk("bp_rsp_s", 32'(rsp_s), 32'hFFFF);
`ifdef HYB_ARB_COUT_EN
      chk("bp_rsp_cout", 32'(rsp_cout), 32'h0);
`endif
      tick();
    end

    // Release: drain and refill at the same edge (ptr = 2)
    rsp_ready = 1'b1;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("rel_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rel_rsp_id", 32'(rsp_id), 32'h2);
    chk("rel_rsp_s", 32'(rsp_s), 32'h2200);

    // Reset mid-operation with buffer full and ptr = 3
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("mid_rst_rsp_s", 32'(rsp_s), 32'h0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ptr0", 32'(req_ready), 32'b0001);
    tick();
    chk("post_rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("post_rst_rsp_s", 32'(rsp_s), 32'h0003);

    // Wrap-around sum on lane 3
    req_valid = 4'b1000;
    #1;
    chk("wrap_req_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    chk("wrap_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wrap_rsp_id", 32'(rsp_id), 32'h3);
    chk("wrap_rsp_s", 32'(rsp_s), 32'h0000);
`ifdef HYB_ARB_COUT_EN
    chk("wrap_rsp_cout", 32'(rsp_cout), 32'h1);
`endif
    tick();
    chk("final_drain", 32'(rsp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
